// File: rtl/processor_pkg.sv
// Shared types and constants for the processor's interrupt entry logic.
// Enum members carry a prefix because both enums name PUSH_PC and PUSH_FLAGS.
package processor_pkg;

    localparam int PC_W = 32;

    typedef enum logic [1:0] {
        OP_NONE        = 2'd0,
        OP_PUSH_PC     = 2'd1,
        OP_PUSH_FLAGS  = 2'd2,
        OP_LOAD_VECTOR = 2'd3
    } inject_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_PUSH_PC,
        ST_PUSH_FLAGS,
        ST_LOAD_VEC,
        ST_WAIT_VEC,
        ST_IN_SERVICE
    } int_state_t;

endpackage

// File: rtl/interrupt_controller_if.sv
// Bundle between the interrupt controller and the fetch/decode/execute pipeline.
// The master side is the pipeline plus the raw interrupt pin.
interface interrupt_controller_if #(
    parameter int PC_W = processor_pkg::PC_W
);
    import processor_pkg::*;

    logic            irq_in;
    logic [PC_W-1:0] fetch_pc;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            vector_loaded;
    logic            rti_retire;
    logic            freeze_fetch;
    logic            inject_valid;
    inject_op_t      inject_op;
    logic [PC_W-1:0] saved_pc;
    logic            in_service;

    modport master (
        output irq_in, fetch_pc, redirect_valid, redirect_pc, vector_loaded, rti_retire,
        input  freeze_fetch, inject_valid, inject_op, saved_pc, in_service
    );

    modport slave (
        input  irq_in, fetch_pc, redirect_valid, redirect_pc, vector_loaded, rti_retire,
        output freeze_fetch, inject_valid, inject_op, saved_pc, in_service
    );

endinterface

// File: rtl/irq_synchronizer.sv
// Multi-flop synchroniser for the raw interrupt pin followed by a rising-edge
// detector; irq_edge is a single-cycle pulse derived only from flops.
module irq_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_async,
    output logic irq_edge
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], irq_async};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign irq_edge = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt entry sequencer: waits for a redirect-free cycle, freezes fetch,
// drains the pipeline, injects PUSH_PC/PUSH_FLAGS/LOAD_VECTOR, masks until RTI.
module interrupt_controller #(
    parameter int SYNC_STAGES  = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int PC_W         = processor_pkg::PC_W
) (
    input  logic                   clk,
    input  logic                   rst,
    interrupt_controller_if.slave  bus
);
    import processor_pkg::*;

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    int_state_t      state_reg, state_next;
    logic            pending_reg, pending_next;
    logic [CNT_W-1:0] drain_cnt_reg, drain_cnt_next;
    logic [PC_W-1:0] saved_pc_reg, saved_pc_next;
    logic            irq_edge;
    logic            freeze_fetch, inject_valid, in_service;
    inject_op_t      inject_op;

    irq_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .irq_async (bus.irq_in),
        .irq_edge  (irq_edge)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            pending_reg   <= 1'b0;
            drain_cnt_reg <= '0;
            saved_pc_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            drain_cnt_reg <= drain_cnt_next;
            saved_pc_reg  <= saved_pc_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pending_next   = pending_reg | irq_edge;
        drain_cnt_next = drain_cnt_reg;
        saved_pc_next  = saved_pc_reg;
        freeze_fetch   = 1'b0;
        inject_valid   = 1'b0;
        inject_op      = OP_NONE;
        in_service     = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                // An edge landing on the entry cycle stays pending for the next entry.
                if (pending_reg && !bus.redirect_valid) begin
                    state_next     = ST_DRAIN;
                    saved_pc_next  = bus.fetch_pc;
                    drain_cnt_next = CNT_W'(DRAIN_CYCLES - 1);
                    pending_next   = irq_edge;
                end
            end
            ST_DRAIN: begin
                freeze_fetch = 1'b1;
                if (bus.redirect_valid) saved_pc_next = bus.redirect_pc;
                if (drain_cnt_reg == '0) state_next = ST_PUSH_PC;
                else drain_cnt_next = drain_cnt_reg - CNT_W'(1);
            end
            ST_PUSH_PC: begin
                freeze_fetch = 1'b1;
                inject_valid = 1'b1;
                inject_op    = OP_PUSH_PC;
                state_next   = ST_PUSH_FLAGS;
            end
            ST_PUSH_FLAGS: begin
                freeze_fetch = 1'b1;
                inject_valid = 1'b1;
                inject_op    = OP_PUSH_FLAGS;
                state_next   = ST_LOAD_VEC;
            end
            ST_LOAD_VEC: begin
                freeze_fetch = 1'b1;
                inject_valid = 1'b1;
                inject_op    = OP_LOAD_VECTOR;
                state_next   = ST_WAIT_VEC;
            end
            ST_WAIT_VEC: begin
                freeze_fetch = 1'b1;
                if (bus.vector_loaded) state_next = ST_IN_SERVICE;
            end
            ST_IN_SERVICE: begin
                in_service = 1'b1;
                if (bus.rti_retire) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.freeze_fetch = freeze_fetch;
    assign bus.inject_valid = inject_valid;
    assign bus.inject_op    = inject_op;
    assign bus.in_service   = in_service;
    assign bus.saved_pc     = saved_pc_reg;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: a cycle-position reference model is
// compared every cycle, plus literal expectations taken from the timing walkthrough.
module tb_interrupt_controller;
    import processor_pkg::*;

    localparam int SYNC = 2;
    localparam int DRN  = 3;
    localparam int PW   = PC_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    interrupt_controller_if #(.PC_W(PW)) bus();

    interrupt_controller #(
        .SYNC_STAGES  (SYNC),
        .DRAIN_CYCLES (DRN),
        .PC_W         (PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int inj_count = 0;
    int cyc;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Reference model: m_t is the position inside an entry sequence counted from
    // the first frozen cycle (-1 when no sequence is running).
    logic [SYNC:0]   m_hist;
    logic            m_pend, m_svc, m_edge;
    int              m_t;
    logic [PW-1:0]   m_saved;

    assign m_edge = m_hist[SYNC-1] & ~m_hist[SYNC];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hist  <= '0;
            m_pend  <= 1'b0;
            m_svc   <= 1'b0;
            m_t     <= -1;
            m_saved <= '0;
        end else begin
            m_hist <= {m_hist[SYNC-1:0], bus.irq_in};
            if (!m_svc && m_t < 0) begin
                if (m_pend && !bus.redirect_valid) begin
                    m_t     <= 0;
                    m_saved <= bus.fetch_pc;
                    m_pend  <= m_edge;
                end else begin
                    m_pend <= m_pend | m_edge;
                end
            end else begin
                m_pend <= m_pend | m_edge;
                if (m_svc) begin
                    if (bus.rti_retire) m_svc <= 1'b0;
                end else begin
                    if (m_t < DRN && bus.redirect_valid) m_saved <= bus.redirect_pc;
                    if (m_t >= DRN + 3) begin
                        if (bus.vector_loaded) begin
                            m_t   <= -1;
                            m_svc <= 1'b1;
                        end
                    end else begin
                        m_t <= m_t + 1;
                    end
                end
            end
        end
    end

    initial begin
        logic       e_freeze, e_valid;
        logic [1:0] e_op;
        forever begin
            @(negedge clk);
            e_freeze = (m_t >= 0);
            e_valid  = (m_t >= DRN) && (m_t < DRN + 3);
            e_op     = e_valid ? 2'(m_t - DRN + 1) : 2'd0;
            n_checks++;
            if (bus.freeze_fetch !== e_freeze || bus.inject_valid !== e_valid ||
                bus.inject_op !== e_op || bus.in_service !== m_svc || bus.saved_pc !== m_saved) begin
                n_fail++;
                $display("FAIL model_compare t=%0t got freeze=%b valid=%b op=%0d svc=%b saved=%h want freeze=%b valid=%b op=%0d svc=%b saved=%h",
                         $time, bus.freeze_fetch, bus.inject_valid, bus.inject_op, bus.in_service, bus.saved_pc,
                         e_freeze, e_valid, e_op, m_svc, m_saved);
            end
            if (bus.inject_valid === 1'b1) inj_count++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
        $display("check %s got %h want %h", name, got, want);
    endtask

    task automatic to_cycle(input int n);
        int k;
        k = n - cyc;
        if (k < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL schedule: at cycle %0d want cycle %0d", cyc, n);
        end
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.irq_in = 1'b0;
        bus.fetch_pc = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.vector_loaded = 1'b0;
        bus.rti_retire = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_freeze", 32'(bus.freeze_fetch), 0);
        check("reset_saved_pc", bus.saved_pc, 0);
        rst = 1'b0;

        // Single interrupt
        bus.fetch_pc = 32'h40;
        to_cycle(10); bus.irq_in = 1'b1;
        to_cycle(13); check("freeze_c13", 32'(bus.freeze_fetch), 0);
        to_cycle(14); check("freeze_c14", 32'(bus.freeze_fetch), 1);
        to_cycle(15); bus.fetch_pc = 32'h44;
        to_cycle(16); check("valid_c16", 32'(bus.inject_valid), 0);
        to_cycle(17); check("op_c17", 32'(bus.inject_op), 1);
                      check("saved_c17", bus.saved_pc, 32'h40);
        to_cycle(18); check("op_c18", 32'(bus.inject_op), 2);
        to_cycle(19); check("op_c19", 32'(bus.inject_op), 3);
        to_cycle(20); check("valid_c20", 32'(bus.inject_valid), 0);
        to_cycle(22); bus.vector_loaded = 1'b1;
        to_cycle(23); bus.vector_loaded = 1'b0;
                      check("svc_c23", 32'(bus.in_service), 1);
                      check("freeze_c23", 32'(bus.freeze_fetch), 0);

        // Masking while in service, then back-to-back entry with redirect in DRAIN
        to_cycle(24); bus.irq_in = 1'b0;
        to_cycle(26); bus.irq_in = 1'b1; bus.fetch_pc = 32'h80;
        to_cycle(32); check("masked_valid", 32'(bus.inject_valid), 0);
                      check("masked_svc", 32'(bus.in_service), 1);
        to_cycle(33); bus.rti_retire = 1'b1;
        to_cycle(34); bus.rti_retire = 1'b0;
                      check("rti_idle_svc", 32'(bus.in_service), 0);
                      check("rti_idle_freeze", 32'(bus.freeze_fetch), 0);
        to_cycle(35); check("b2b_freeze", 32'(bus.freeze_fetch), 1);
                      check("b2b_saved", bus.saved_pc, 32'h80);
        to_cycle(36); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
        to_cycle(37); bus.redirect_valid = 1'b0;
        to_cycle(38); check("redir_op", 32'(bus.inject_op), 1);
                      check("redir_saved", bus.saved_pc, 32'h100);
        to_cycle(42); bus.vector_loaded = 1'b1;
        to_cycle(43); bus.vector_loaded = 1'b0;
        to_cycle(45); bus.rti_retire = 1'b1;
        to_cycle(46); bus.rti_retire = 1'b0; bus.irq_in = 1'b0;

        // Redirect held while pending blocks entry
        to_cycle(50); bus.irq_in = 1'b1; bus.fetch_pc = 32'h200; bus.redirect_pc = 32'h300;
        to_cycle(52); bus.redirect_valid = 1'b1;
        to_cycle(56); bus.redirect_valid = 1'b0;
                      check("blocked_freeze", 32'(bus.freeze_fetch), 0);
        to_cycle(57); check("unblocked_freeze", 32'(bus.freeze_fetch), 1);
                      check("unblocked_saved", bus.saved_pc, 32'h200);
        to_cycle(64); bus.vector_loaded = 1'b1;
        to_cycle(65); bus.vector_loaded = 1'b0;
        to_cycle(67); bus.rti_retire = 1'b1;
        to_cycle(68); bus.rti_retire = 1'b0; bus.irq_in = 1'b0;

        // Three edges merged into one entry
        to_cycle(70); bus.redirect_valid = 1'b1; base = inj_count; bus.irq_in = 1'b1;
        to_cycle(71); bus.irq_in = 1'b0;
        to_cycle(72); bus.irq_in = 1'b1;
        to_cycle(73); bus.irq_in = 1'b0;
        to_cycle(74); bus.irq_in = 1'b1;
        to_cycle(75); bus.irq_in = 1'b0;
        to_cycle(78); bus.redirect_valid = 1'b0;
        to_cycle(79); check("merged_freeze", 32'(bus.freeze_fetch), 1);
        to_cycle(86); bus.vector_loaded = 1'b1;
        to_cycle(87); bus.vector_loaded = 1'b0;
        to_cycle(89); bus.rti_retire = 1'b1;
        to_cycle(90); bus.rti_retire = 1'b0;
        to_cycle(95); check("merged_idle_freeze", 32'(bus.freeze_fetch), 0);
                      check("merged_inject_count", 32'(inj_count - base), 3);

        // Reset during PUSH_FLAGS
        to_cycle(100); bus.irq_in = 1'b1; bus.fetch_pc = 32'h500;
        to_cycle(108); check("pre_reset_op", 32'(bus.inject_op), 2);
        rst = 1'b1;
        #1;
        check("rst_freeze", 32'(bus.freeze_fetch), 0);
        check("rst_valid", 32'(bus.inject_valid), 0);
        check("rst_op", 32'(bus.inject_op), 0);
        check("rst_saved", bus.saved_pc, 0);
        bus.irq_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        base = inj_count;
        repeat (15) @(posedge clk);
        #1;
        check("post_reset_inject_count", 32'(inj_count - base), 0);
        check("post_reset_freeze", 32'(bus.freeze_fetch), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
